// File: rtl/wb_regfile.sv
// wb_regfile -- writeback stage of the Y86-64 pipeline.
//
// Commits W_valE / W_valM into a 15-entry x 64-bit program register file,
// tracks the architectural status with a sticky halt, and counts retired
// instructions. Reads are purely combinational from the stored state, so a
// register written on an edge shows its new value only after that edge.
// Forwarding of in-flight W values to decode happens outside this block.
//
// Ports:
//   clk                      pipeline clock, rising-edge state updates
//   rst                      synchronous active-high reset
//   W_stat, W_icode          status / icode of the instruction in W
//   W_destE, W_destM         destination IDs for valE / valM (15 = none)
//   W_valE, W_valM           ALU result / memory read result
//   d_srcA, d_srcB           decode read addresses
//   d_rvalA, d_rvalB         decode read data (0 for ID 15)
//   dbg_addr, dbg_data       debug read port (0 for ID 15)
//   stat                     architectural status code
//   halted                   sticky: no further commits until reset
//   retired                  committed-instruction count, wraps mod 2^64
module wb_regfile #(
    parameter int         NREG = 15,
    parameter logic [3:0] SBUB = 4'h0,
    parameter logic [3:0] SAOK = 4'h1,
    parameter logic [3:0] SHLT = 4'h2,
    parameter logic [3:0] SADR = 4'h3,
    parameter logic [3:0] SINS = 4'h4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  W_stat,
    input  logic [3:0]  W_icode,
    input  logic [3:0]  W_destE,
    input  logic [3:0]  W_destM,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [63:0] d_rvalA,
    output logic [63:0] d_rvalB,
    input  logic [3:0]  dbg_addr,
    output logic [63:0] dbg_data,
    output logic [3:0]  stat,
    output logic        halted,
    output logic [63:0] retired
);

    logic [63:0] regs [NREG];

    logic       commit;
    logic       fault;
    logic       wr_e;
    logic       wr_m;
    logic [3:0] fault_code;

    // Any ID at or beyond NREG (in practice only RNONE) reads as zero.
    function automatic logic [63:0] read_reg(input logic [3:0] addr);
        if (int'(addr) < NREG)
            return regs[addr];
        return 64'd0;
    endfunction

    // Unrecognised status codes are folded into an illegal-instruction fault.
    function automatic logic [3:0] map_fault(input logic [3:0] code);
        if (code == SHLT || code == SADR || code == SINS)
            return code;
        return SINS;
    endfunction

    always_comb begin
        commit     = !halted && (W_stat == SAOK);
        fault      = !halted && (W_stat != SAOK) && (W_stat != SBUB);
        fault_code = map_fault(W_stat);
        // popq %rsp names the same register twice; the memory value wins.
        wr_e       = commit && (int'(W_destE) < NREG) && (W_destE != W_destM);
        wr_m       = commit && (int'(W_destM) < NREG);
    end

    always_comb begin
        d_rvalA  = read_reg(d_srcA);
        d_rvalB  = read_reg(d_srcB);
        dbg_data = read_reg(dbg_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= 64'd0;
            halted  <= 1'b0;
            retired <= 64'd0;
            stat    <= SAOK;
        end else begin
            if (wr_e)
                regs[W_destE] <= W_valE;
            if (wr_m)
                regs[W_destM] <= W_valM;
            if (commit)
                retired <= retired + 64'd1;
            if (fault) begin
                halted <= 1'b1;
                stat   <= fault_code;
            end
        end
    end

    // W_icode is carried for visibility only; it never gates a commit.
    logic unused_icode;
    assign unused_icode = ^W_icode;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile: reset state, single and dual writes,
// popq %rsp, bubbles, fault/halt stickiness, unknown status codes and reset
// out of the halted state.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [3:0]  W_stat;
    logic [3:0]  W_icode;
    logic [3:0]  W_destE;
    logic [3:0]  W_destM;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [63:0] d_rvalA;
    logic [63:0] d_rvalB;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;
    logic [3:0]  stat;
    logic        halted;
    logic [63:0] retired;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .W_stat   (W_stat),
        .W_icode  (W_icode),
        .W_destE  (W_destE),
        .W_destM  (W_destM),
        .W_valE   (W_valE),
        .W_valM   (W_valM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .d_rvalA  (d_rvalA),
        .d_rvalB  (d_rvalB),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .stat     (stat),
        .halted   (halted),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle a little after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] st, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        W_stat  = st;
        W_icode = 4'h6;
        W_destE = de;
        W_valE  = ve;
        W_destM = dm;
        W_valM  = vm;
    endtask

    task automatic idle();
        drive(4'h0, 4'hF, 64'd0, 4'hF, 64'd0);
    endtask

    task automatic test_reset();
        logic [63:0] v;
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            v = dbg_data;
            checks++;
            if (v !== 64'd0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", i, v, 64'd0);
            end
        end
        checks++;
        if (stat !== 4'h1) begin errors++; $display("FAIL reset_stat: got %h expected 1", stat); end
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++;
        if (retired !== 64'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    endtask

    task automatic test_write_read();
        drive(4'h1, 4'd3, 64'h1122334455667788, 4'hF, 64'hDEADDEADDEADDEAD);
        d_srcA = 4'd3;
        d_srcB = 4'hF;
        #1;
        checks++;
        if (d_rvalA !== 64'd0) begin errors++; $display("FAIL wr_same_cycle_old: got %h expected 0", d_rvalA); end
        cyc();
        idle();
        #1;
        checks++;
        if (d_rvalA !== 64'h1122334455667788) begin
            errors++; $display("FAIL wr_after_edge: got %h expected 1122334455667788", d_rvalA);
        end
        checks++;
        if (d_rvalB !== 64'd0) begin errors++; $display("FAIL rnone_read: got %h expected 0", d_rvalB); end
        checks++;
        if (retired !== 64'd1) begin errors++; $display("FAIL wr_retired: got %0d expected 1", retired); end
    endtask

    task automatic test_popq();
        drive(4'h1, 4'd4, 64'h100, 4'd4, 64'hABCD);
        cyc();
        idle();
        dbg_addr = 4'd4;
        #1;
        checks++;
        if (dbg_data !== 64'hABCD) begin errors++; $display("FAIL popq_reg4: got %h expected abcd", dbg_data); end
        checks++;
        if (retired !== 64'd2) begin errors++; $display("FAIL popq_retired: got %0d expected 2", retired); end
    endtask

    task automatic test_dual_and_bubble();
        drive(4'h1, 4'd2, 64'd5, 4'd7, 64'd9);
        cyc();
        drive(4'h0, 4'd2, 64'hFF, 4'hF, 64'd0);
        d_srcA = 4'd2;
        d_srcB = 4'd7;
        #1;
        checks++;
        if (d_rvalA !== 64'd5) begin errors++; $display("FAIL dual_reg2: got %h expected 5", d_rvalA); end
        checks++;
        if (d_rvalB !== 64'd9) begin errors++; $display("FAIL dual_reg7: got %h expected 9", d_rvalB); end
        checks++;
        if (retired !== 64'd3) begin errors++; $display("FAIL dual_retired: got %0d expected 3", retired); end
        cyc();
        // both destinations RNONE: retires without writing
        drive(4'h1, 4'hF, 64'h33, 4'hF, 64'h44);
        #1;
        checks++;
        if (d_rvalA !== 64'd5) begin errors++; $display("FAIL bubble_reg2: got %h expected 5", d_rvalA); end
        checks++;
        if (retired !== 64'd3) begin errors++; $display("FAIL bubble_retired: got %0d expected 3", retired); end
        checks++;
        if (stat !== 4'h1) begin errors++; $display("FAIL bubble_stat: got %h expected 1", stat); end
        cyc();
        idle();
        #1;
        checks++;
        if (retired !== 64'd4) begin errors++; $display("FAIL nodest_retired: got %0d expected 4", retired); end
    endtask

    task automatic test_fault();
        dbg_addr = 4'd1;
        drive(4'h3, 4'hF, 64'd0, 4'd1, 64'hDEAD);
        cyc();
        drive(4'h1, 4'd1, 64'd7, 4'hF, 64'd0);
        #1;
        checks++;
        if (dbg_data !== 64'd0) begin errors++; $display("FAIL fault_reg1: got %h expected 0", dbg_data); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL fault_halted: got %b expected 1", halted); end
        checks++;
        if (stat !== 4'h3) begin errors++; $display("FAIL fault_stat: got %h expected 3", stat); end
        cyc();
        drive(4'h2, 4'hF, 64'd0, 4'hF, 64'd0);
        cyc();
        idle();
        #1;
        checks++;
        if (dbg_data !== 64'd0) begin errors++; $display("FAIL halted_reg1: got %h expected 0", dbg_data); end
        checks++;
        if (stat !== 4'h3) begin errors++; $display("FAIL halted_stat: got %h expected 3", stat); end
        checks++;
        if (retired !== 64'd4) begin errors++; $display("FAIL halted_retired: got %0d expected 4", retired); end
    endtask

    task automatic test_reset_from_halt();
        rst = 1'b1;
        drive(4'h1, 4'd5, 64'h55, 4'hF, 64'd0);
        cyc();
        rst = 1'b0;
        drive(4'h1, 4'd5, 64'h77, 4'hF, 64'd0);
        dbg_addr = 4'd5;
        d_srcA   = 4'd2;
        #1;
        checks++;
        if (dbg_data !== 64'd0) begin errors++; $display("FAIL rst_reg5: got %h expected 0", dbg_data); end
        checks++;
        if (d_rvalA !== 64'd0) begin errors++; $display("FAIL rst_reg2: got %h expected 0", d_rvalA); end
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
        checks++;
        if (stat !== 4'h1) begin errors++; $display("FAIL rst_stat: got %h expected 1", stat); end
        checks++;
        if (retired !== 64'd0) begin errors++; $display("FAIL rst_retired: got %0d expected 0", retired); end
        cyc();
        idle();
        #1;
        checks++;
        if (dbg_data !== 64'h77) begin errors++; $display("FAIL post_rst_reg5: got %h expected 77", dbg_data); end
        checks++;
        if (retired !== 64'd1) begin errors++; $display("FAIL post_rst_retired: got %0d expected 1", retired); end
    endtask

    task automatic test_unknown_stat();
        drive(4'h9, 4'd6, 64'h66, 4'hF, 64'd0);
        dbg_addr = 4'd6;
        cyc();
        idle();
        #1;
        checks++;
        if (stat !== 4'h4) begin errors++; $display("FAIL unknown_stat: got %h expected 4", stat); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL unknown_halted: got %b expected 1", halted); end
        checks++;
        if (dbg_data !== 64'd0) begin errors++; $display("FAIL unknown_reg6: got %h expected 0", dbg_data); end
    endtask

    initial begin
        rst      = 1'b1;
        d_srcA   = 4'hF;
        d_srcB   = 4'hF;
        dbg_addr = 4'd0;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_popq();
        test_dual_and_bubble();
        test_fault();
        test_reset_from_halt();
        test_unknown_stat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
